// File: rtl/spi_reg_master.sv
// spi_reg_master: SPI mode-0 initiator that turns one valid/ready request into one
// CS-framed register frame ({write, zero pad, addr} command byte, then REG_W data bits, MSB first).
module spi_reg_master #(
  parameter int ADDR_W  = 3,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [REG_W-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [REG_W-1:0]  rsp_rdata,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int N     = 8 + REG_W;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(N);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t             state_r;
  logic [DIV_W-1:0]   div_r;
  logic [BIT_W-1:0]   bit_r;
  logic               phase_hi_r;
  logic [N-1:0]       tx_r;
  logic [REG_W-1:0]   rx_r;
  logic               ready_r;
  logic               busy_r;
  logic               rsp_valid_r;
  logic [REG_W-1:0]   rdata_r;
  logic               cs_n_r;
  logic               sclk_r;
  logic               mosi_r;

  logic [7:0]         cmd_s;
  logic [N-1:0]       frame_s;

  // Command byte and full frame word built from the live request fields.
  always_comb begin
    cmd_s                = 8'h00;
    cmd_s[7]             = req_write;
    cmd_s[ADDR_W-1:0]    = req_addr;
    if (req_write) begin
      frame_s = {cmd_s, req_wdata};
    end else begin
      frame_s = {cmd_s, {REG_W{1'b0}}};
    end
  end

  // Frame sequencer; every SPI pin and handshake output is a register of this block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      div_r       <= {DIV_W{1'b0}};
      bit_r       <= {BIT_W{1'b0}};
      phase_hi_r  <= 1'b0;
      tx_r        <= {N{1'b0}};
      rx_r        <= {REG_W{1'b0}};
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rdata_r     <= {REG_W{1'b0}};
      cs_n_r      <= 1'b1;
      sclk_r      <= 1'b0;
      mosi_r      <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            state_r <= ST_SETUP;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            cs_n_r  <= 1'b0;
            mosi_r  <= frame_s[N-1];
            tx_r    <= {frame_s[N-2:0], 1'b0};
            div_r   <= {DIV_W{1'b0}};
            bit_r   <= {BIT_W{1'b0}};
          end
        end
        ST_SETUP: begin
          if (div_r == DIV_LAST) begin
            div_r      <= {DIV_W{1'b0}};
            state_r    <= ST_SHIFT;
            sclk_r     <= 1'b1;
            phase_hi_r <= 1'b1;
            rx_r       <= {rx_r[REG_W-2:0], spi_miso};
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        ST_SHIFT: begin
          if (div_r != DIV_LAST) begin
            div_r <= div_r + DIV_W'(1);
          end else begin
            div_r <= {DIV_W{1'b0}};
            if (phase_hi_r) begin
              sclk_r     <= 1'b0;
              phase_hi_r <= 1'b0;
              // No bit follows the last one, so MOSI keeps the LSB through HOLD.
              if (bit_r != BIT_LAST) begin
                mosi_r <= tx_r[N-1];
                tx_r   <= {tx_r[N-2:0], 1'b0};
              end
            end else if (bit_r == BIT_LAST) begin
              state_r <= ST_HOLD;
            end else begin
              bit_r      <= bit_r + BIT_W'(1);
              sclk_r     <= 1'b1;
              phase_hi_r <= 1'b1;
              rx_r       <= {rx_r[REG_W-2:0], spi_miso};
            end
          end
        end
        ST_HOLD: begin
          if (div_r == DIV_LAST) begin
            div_r       <= {DIV_W{1'b0}};
            state_r     <= ST_GAP;
            cs_n_r      <= 1'b1;
            mosi_r      <= 1'b0;
            rsp_valid_r <= 1'b1;
            rdata_r     <= rx_r;
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        ST_GAP: begin
          if (div_r == DIV_LAST) begin
            div_r   <= {DIV_W{1'b0}};
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          cs_n_r  <= 1'b1;
          sclk_r  <= 1'b0;
          mosi_r  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rdata_r;
  assign spi_cs_n  = cs_n_r;
  assign spi_clk   = sclk_r;
  assign spi_mosi  = mosi_r;

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master: default instance (CLK_DIV=4) and a CLK_DIV=1 instance,
// each with a small mode-0 slave model that records MOSI and drives a fixed MISO word.
module tb_spi_reg_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Default instance
  logic       req_valid, req_ready, req_write, rsp_valid, busy;
  logic [2:0] req_addr;
  logic [7:0] req_wdata, rsp_rdata;
  logic       spi_cs_n, spi_clk, spi_mosi, spi_miso;

  spi_reg_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  // CLK_DIV=1 instance
  logic       req_valid1, req_ready1, req_write1, rsp_valid1, busy1;
  logic [2:0] req_addr1;
  logic [7:0] req_wdata1, rsp_rdata1;
  logic       spi_cs_n1, spi_clk1, spi_mosi1, spi_miso1;

  spi_reg_master #(.ADDR_W(3), .REG_W(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .busy(busy1),
    .spi_cs_n(spi_cs_n1), .spi_clk(spi_clk1), .spi_mosi(spi_mosi1), .spi_miso(spi_miso1)
  );

  // Slave models: shift out slv_word MSB first, change MISO on falling SCLK, capture MOSI on rising.
  logic [15:0] slv_word = 16'h0000, slv_word1 = 16'h0000;
  logic [15:0] mosi_cap = 16'h0000, mosi_cap1 = 16'h0000;
  int          rises = 0, rises1 = 0, sidx = 0, sidx1 = 0;

  initial begin spi_miso = 1'b0; spi_miso1 = 1'b0; end

  always @(negedge spi_cs_n) begin sidx = 15; spi_miso = slv_word[15]; end
  always @(negedge spi_clk) if (!spi_cs_n && sidx > 0) begin sidx = sidx - 1; spi_miso = slv_word[sidx]; end
  always @(posedge spi_clk) begin mosi_cap = {mosi_cap[14:0], spi_mosi}; rises = rises + 1; end

  always @(negedge spi_cs_n1) begin sidx1 = 15; spi_miso1 = slv_word1[15]; end
  always @(negedge spi_clk1) if (!spi_cs_n1 && sidx1 > 0) begin sidx1 = sidx1 - 1; spi_miso1 = slv_word1[sidx1]; end
  always @(posedge spi_clk1) begin mosi_cap1 = {mosi_cap1[14:0], spi_mosi1}; rises1 = rises1 + 1; end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) at negedges until rsp_valid; lat counts cycles since the call.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < 400) begin @(negedge clk); n++; end
  endtask

  // One frame on the default instance; lat = cycles from the accept cycle to rsp_valid.
  task automatic do_frame(input logic wr, input logic [2:0] a, input logic [7:0] d,
                          output int lat, output int cs_low, output int bad_clk);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    rises = 0; mosi_cap = 16'h0000;
    @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_addr = ~a; req_wdata = ~d;
    lat = 1; cs_low = 0; bad_clk = 0;
    while (!rsp_valid && lat < 400) begin
      if (!spi_cs_n) cs_low++;
      if (spi_clk && spi_cs_n) bad_clk++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, cs_low, bad, n, t0, t1, hi_cnt, extra, hi1, dbl1;
    logic prev_clk1;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 3'd0; req_wdata = 8'h00;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = 3'd0; req_wdata1 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_clk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write addr 5, data A5; slave returns 0x96 in its data bits.
    slv_word = 16'hFF96;
    do_frame(1'b1, 3'd5, 8'hA5, lat, cs_low, bad);
    check("wr_latency", lat, 137);
    check("wr_cs_low", cs_low, 136);
    check("wr_sclk_cs_hi", bad, 0);
    check("wr_rises", rises, 16);
    check("wr_mosi", mosi_cap, 16'h85A5);
    check("wr_rdata", rsp_rdata, 8'h96);
    @(negedge clk);
    check("wr_rsp_pulse", rsp_valid, 0);
    wait_ready(n);
    check("wr_ready_after_gap", n, 3);

    // Read addr 3; slave drives 0x3C.
    slv_word = 16'h003C;
    do_frame(1'b0, 3'd3, 8'hFF, lat, cs_low, bad);
    check("rd_latency", lat, 137);
    check("rd_mosi", mosi_cap, 16'h0300);
    check("rd_rdata", rsp_rdata, 8'h3C);
    repeat (10) @(negedge clk);
    check("rd_rdata_hold", rsp_rdata, 8'h3C);

    // Back-to-back with req_valid held; fields change mid-frame to the second request.
    slv_word = 16'h0000;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd1; req_wdata = 8'h11;
    rises = 0; mosi_cap = 16'h0000;
    check("b2b_ready0", req_ready, 1);
    t0 = cyc; hi_cnt = 0;
    @(negedge clk);
    for (int i = 0; i < 400 && !req_ready; i++) begin
      if (spi_cs_n) hi_cnt++;
      if (cyc - t0 == 50) begin req_addr = 3'd2; req_wdata = 8'h22; end
      @(negedge clk);
    end
    if (spi_cs_n) hi_cnt++;
    t1 = cyc;
    check("b2b_period", t1 - t0, 141);
    // Four GAP cycles plus the accept cycle of the next frame.
    check("b2b_cs_high", hi_cnt, 5);
    check("b2b_mosi1", mosi_cap, 16'h8111);
    rises = 0; mosi_cap = 16'h0000;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(lat);
    check("b2b_lat2", lat, 136);
    check("b2b_mosi2", mosi_cap, 16'h8222);
    wait_ready(n);

    // req_valid pulsed while busy must be ignored.
    slv_word = 16'h003C;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd4; req_wdata = 8'h0F;
    rises = 0; mosi_cap = 16'h0000;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    req_valid = 1'b1; req_addr = 3'd5; req_wdata = 8'hFF;
    check("busy_ready", req_ready, 0);
    check("busy_flag", busy, 1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(lat);
    check("busy_mosi", mosi_cap, 16'h840F);
    wait_ready(n);
    check("busy_ready_gap", n, 4);
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!spi_cs_n || rsp_valid) extra++;
    end
    check("busy_no_extra", extra, 0);

    // Reset at cycle 40 of a write frame.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd6; req_wdata = 8'hC3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (39) @(negedge clk);
    check("abort_pre_cs", spi_cs_n, 0);
    rst = 1'b1;
    #1;
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_clk, 0);
    check("abort_mosi", spi_mosi, 0);
    check("abort_ready", req_ready, 1);
    check("abort_rdata", rsp_rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid || !spi_cs_n) extra++;
    end
    check("abort_no_rsp", extra, 0);
    slv_word = 16'h00E7;
    do_frame(1'b1, 3'd6, 8'h5A, lat, cs_low, bad);
    check("post_rst_lat", lat, 137);
    check("post_rst_mosi", mosi_cap, 16'h865A);
    check("post_rst_rdata", rsp_rdata, 8'hE7);
    wait_ready(n);

    // CLK_DIV=1 instance: read addr 7, slave drives 0xC3.
    slv_word1 = 16'h00C3;
    @(negedge clk);
    req_valid1 = 1'b1; req_write1 = 1'b0; req_addr1 = 3'd7; req_wdata1 = 8'h99;
    rises1 = 0; mosi_cap1 = 16'h0000;
    check("d1_ready", req_ready1, 1);
    @(negedge clk);
    req_valid1 = 1'b0;
    check("d1_busy", busy1, 1);
    lat = 1; hi1 = 0; dbl1 = 0; prev_clk1 = 1'b0;
    while (!rsp_valid1 && lat < 400) begin
      if (spi_clk1) hi1++;
      if (spi_clk1 && prev_clk1) dbl1++;
      prev_clk1 = spi_clk1;
      @(negedge clk);
      lat++;
    end
    check("d1_latency", lat, 35);
    check("d1_rises", rises1, 16);
    check("d1_sclk_hi_cycles", hi1, 16);
    check("d1_sclk_double_hi", dbl1, 0);
    check("d1_mosi", mosi_cap1, 16'h0700);
    check("d1_rdata", rsp_rdata1, 8'hC3);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
